// File: rtl/dmem_pkg.sv
// Shared constants and FSM state type for the data-memory responder.
package dmem_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane alignment for dmem_responder accesses.
// Misalign detection is compiled in only when DMEM_MISALIGN_CHK_EN is defined.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]      off,
  input  logic [1:0]      size,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rword,
  output logic [3:0]      mask,
  output logic [XLEN-1:0] wdata_sh,
  output logic [XLEN-1:0] rdata_al,
  output logic            misalign
);

  logic [3:0]      base_mask;
  logic [XLEN-1:0] size_mask;

  // Size code 3 falls into the word case.
  always_comb begin
    base_mask = 4'b1111;
    size_mask = 32'hFFFF_FFFF;
    case (size)
      SZ_B: begin
        base_mask = 4'b0001;
        size_mask = 32'h0000_00FF;
      end
      SZ_H: begin
        base_mask = 4'b0011;
        size_mask = 32'h0000_FFFF;
      end
      default: begin
        base_mask = 4'b1111;
        size_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  // Lanes pushed past lane 3 are simply dropped; reads shift in zeros.
  assign mask     = base_mask << off;
  assign wdata_sh = wdata << {off, 3'b000};
  assign rdata_al = (rword >> {off, 3'b000}) & size_mask;

`ifdef DMEM_MISALIGN_CHK_EN
  assign misalign = ((size == SZ_H) && off[0]) || (size[1] && (off != 2'd0));
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable response latency.
// Optional misalign checking is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [31:0]     req_addr,
  input  logic [1:0]      req_size,
  input  logic [31:0]     req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mem [DEPTH];

  logic [AW-1:0]   idx;
  logic [1:0]      off;
  logic            accept;
  logic            store_en;
  logic [3:0]      mask;
  logic [XLEN-1:0] wdata_sh;
  logic [XLEN-1:0] rdata_al;
  logic            misalign;
  logic            unused_addr;

  assign idx         = req_addr[AW+1:2];
  assign off         = req_addr[1:0];
  assign unused_addr = ^req_addr[31:AW+2];

  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign store_en  = accept && req_wen && !misalign;

  dmem_lane_align u_align (
    .off      (off),
    .size     (req_size),
    .wdata    (req_wdata),
    .rword    (mem[idx]),
    .mask     (mask),
    .wdata_sh (wdata_sh),
    .rdata_al (rdata_al),
    .misalign (misalign)
  );

  // The array is deliberately left out of reset; only enabled lanes change.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
      end
    end
  end

  // Response data is captured at acceptance and held until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_rdata <= (req_wen || misalign) ? 32'h0 : rdata_al;
            rsp_err   <= misalign;
            cnt       <= '0;
            state     <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the load/store requests the NPC execute stage issues today through DPI calls. It holds a word-organised on-chip data array, accepts one request at a time over a valid/ready channel, and answers after a programmable latency. It aligns byte/half/word accesses to the addressed lane, so the requester handles only sign extension.

## Interface
- `DEPTH`, 1024: data array size in 32-bit words; must be a power of two.
- `LATENCY`, 1: cycles from request acceptance to `rsp_valid`; must be ≥1.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: responder can accept a request.
- `req_wen` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address.
- `req_size` input 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `req_wdata` input 32: store data, right-aligned, so byte stores use bits 7:0.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: requester accepts the response.
- `rsp_rdata` output 32: load data, right-aligned and zero-filled above the access size; 0 for stores.
- `rsp_err` output 1: misaligned access; always 0 when the check is compiled out.

## Operation
- Word index = `req_addr[log2(DEPTH)+1:2]`. Higher address bits are ignored, so addresses wrap modulo 4·DEPTH bytes.
- Lane offset `off = req_addr[1:0]`. Base lane mask is 0001, 0011 or 1111 by size. Effective mask = base << off, truncated to 4 bits.
- Store: byte lane i is written with `(req_wdata << 8·off)` lane i wherever the effective mask bit is set. Other lanes are unchanged.
- Load: `rsp_rdata = (word >> 8·off)`, then masked to the access size. Lanes shifted in from above lane 3 read as 0.
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`, go to WAIT; if `LATENCY`=1, go directly to RESP.
  - WAIT: counter counts `LATENCY-1` cycles, then go to RESP.
  - RESP: `rsp_valid`=1, holding `rsp_rdata` and `rsp_err` stable. On `rsp_ready`, go to IDLE.
- Only one transaction is outstanding at a time. `req_ready`=0 in WAIT and RESP.
- A store commits to the array on the acceptance edge. Load data is captured on the acceptance edge into a response register.
- A store followed by a load to the same word returns the new data.

## Timing
- Acceptance edge T is the first edge where `req_valid && req_ready`.
- `rsp_valid` rises after edge T+LATENCY-1, so it is visible in cycle T+LATENCY.
- Response handshake at edge R returns the FSM to IDLE. The next request can be accepted at edge R+1 at the earliest, giving a peak rate of one request per LATENCY+1 cycles.
- Request inputs are don't-care outside IDLE.
- Reset values:
  - State = IDLE, counter = 0.
  - `rsp_valid`, `rsp_rdata` and `rsp_err` = 0.
  - `req_ready` = 0 while `rst` is high, 1 from the first cycle after deassertion.
- The data array is not reset.
- Reset mid-transaction aborts the transaction and no response is issued. A store already committed at its acceptance edge remains in the array.
- `rsp_ready` held high before RESP has no effect until RESP is reached.

## Configuration
- `DMEM_MISALIGN_CHK_EN` defined:
  - A half access with `off[0]`=1, or a word access with `off`≠0, is flagged.
  - A flagged store is not performed.
  - A flagged load returns `rsp_rdata`=0.
  - A flagged response has `rsp_err`=1. Timing is unchanged.
- `DMEM_MISALIGN_CHK_EN` undefined: `rsp_err` is tied to 0 and misaligned accesses use the truncating lane rules above.

## Structure
- `dmem_pkg` holds:
  - the size encoding constants SZ_B, SZ_H and SZ_W;
  - the FSM state enum IDLE, WAIT, RESP;
  - the width constant XLEN=32.
- Sub-module `dmem_lane_align` is combinational. It takes off, size, wdata and the stored word. It produces the effective mask, the shifted write data, the aligned read data and the misalign flag.

## Test plan
- Word store then load, LATENCY=1: store 0xDEADBEEF at 0x100, then load word at 0x100 → 0xDEADBEEF. `rsp_valid` is visible in the cycle after each acceptance.
- Byte store and aligned load: store byte 0xA5 at 0x103 over word 0x11223344 → word reads 0xA5223344. Load byte at 0x103 → 0x000000A5.
- Back-pressure, LATENCY=3: hold `rsp_ready`=0 for 5 cycles. `rsp_valid` stays 1 with stable data and `req_ready` stays 0. After the handshake, the next request is accepted one cycle later.
- Wrap with DEPTH=1024: store word at 0x1000 → load at 0x0000 returns that word.
- Misaligned access with `DMEM_MISALIGN_CHK_EN` defined: word store at 0x102 → `rsp_err`=1 and the array is unchanged. Without the macro, the half load at 0x103 of 0x11223344 → 0x00000011.
- Reset during WAIT, LATENCY=4: assert `rst` two cycles after accepting a load. No `rsp_valid` is issued and `req_ready` returns to 1 the cycle after release.
